nubus_slave_resp: RTL
=====================

# nubus_slave_resp

Clocked NuBus slave responder: the target-side counterpart to the card's master bus driver. Watches START/ACK/TM/AD at every clock, decodes accesses to this card's slot (and optional super-slot) space, hands the transaction to the local bus, and drives the ACK cycle with a status code. It also tracks lock/null attention cycles. Sits between the NuBus transceivers and the card's local memory/register decode; all NuBus signals are active-high "asserted" levels at this boundary, with the board transceivers providing the inversion.

## Interface
- `WAIT_MIN`, 0: minimum cycles between `lcl_req` assertion and ACK.
- `TMO_CYCLES`, 200: local-response timeout in clocks; must be < 255, the master bus timeout.
- `SUPER_EN`, 1: also respond to super-slot space.
- `nub_clkn`  in  1  NuBus clock; all state updates on its rising edge.
- `nub_resetn`  in  1  reset, asynchronous, active-low.
- `ID`  in  4  slot ID from backplane.
- `START`  in  1  START asserted.
- `ACK`  in  1  ACK asserted; sampled only together with START.
- `TM1`, `TM0`  in  1 each  transfer mode at START.
- `AD`  in  32  address/data lines.
- `lcl_req`  out  1  local transaction request.
- `lcl_addr`  out  30  latched AD[31:2].
- `lcl_mode`  out  4  latched {TM1,TM0,AD[1:0]}; TM1=1 means read.
- `lcl_rdy`  in  1  local side complete.
- `lcl_err`  in  1  local error; qualified by `lcl_rdy`.
- `lcl_busy`  in  1  local side requests retry; qualified by `lcl_rdy`.
- `lcl_lock`  out  1  set while a lock-attention is in effect.
- `ack_out`  out  1  drive ACK.
- `tm1_out`, `tm0_out`  out  1 each  status driven with ACK.
- `ackoe`  out  1  output enable for ACK/TM transceivers.
- `dataoe`  out  1  drive AD with read data.

## Operation
- Address cycle: START=1 with ACK=0. Hit when AD[31:28]==4'hF and AD[27:24]==ID (slot space), or, with `SUPER_EN`, when AD[31:28]==ID and ID != 4'hF.
- Status codes, as {tm1_out,tm0_out}: 11 complete, 01 error, 00 try-again-later. Code 10 is never driven.
- States:
  - IDLE: on a hit, latch `lcl_addr` and `lcl_mode`, clear the counters, go to REQ. A miss stays in IDLE.
  - REQ: `lcl_req`=1. Increment the wait counter and the timeout counter each cycle. When `lcl_rdy`=1 and the wait counter >= `WAIT_MIN`, select a status and go to ACK:
    - `lcl_err`=1 gives 01.
    - `lcl_busy`=1 gives 00.
    - Otherwise 11.
    - If both `lcl_err` and `lcl_busy` are set, error wins.
  - REQ timeout: when the timeout counter reaches `TMO_CYCLES`-1 without a qualifying `lcl_rdy`, go to ACK with status 01.
  - ACK: one cycle with `ack_out`=1, `ackoe`=1 and the status on the TM outputs. `dataoe`=1 only for a read with status 11. Then go to IDLE.
- Attention cycles (START=1, ACK=1) are honoured in any state:
  - {TM1,TM0}=01 (lock-attn) sets `lcl_lock`.
  - 11 (null-attn) clears `lcl_lock`.
  - Other codes are ignored.
  - An attention cycle never starts a transaction.
- START is ignored while in REQ or ACK.
- `lcl_rdy` in IDLE or ACK is ignored.

## Timing
- Outputs are registered, apart from decoding the current state. `lcl_req`, `ack_out`, `ackoe` and `dataoe` are pure state decodes.
- START sampled at edge N (hit): `lcl_req`=1 from edge N+1.
- First `lcl_rdy` sampled at edge M, with M >= N+1+`WAIT_MIN`: ACK outputs are asserted from edge M+1 for exactly one cycle, and `lcl_req` drops at M+1. With `WAIT_MIN`=0 and `lcl_rdy` tied high, ACK is asserted two cycles after the START cycle.
- Timeout: ACK with 01 at edge N+1+`TMO_CYCLES`.
- Back-to-back transactions: a START sampled in the cycle immediately after ACK is accepted.
- Reset (asynchronous, any time, including mid-REQ or ACK):
  - State is IDLE.
  - All outputs are 0; `lcl_addr`=0, `lcl_mode`=0, `lcl_lock`=0, counters 0.
  - A transaction interrupted by reset is dropped and never acknowledged.
- Counters are 8 bits and saturate; they never wrap.

## Structure
- Package `nubus_pkg`:
  - state enum `nbs_state_t` {IDLE, REQ, ACK}
  - status constants `ST_COMPLETE`=2'b11, `ST_ERROR`=2'b01, `ST_RETRY`=2'b00
  - attention constants `ATTN_LOCK`=2'b01, `ATTN_NULL`=2'b11
  - `SLOT_SPACE`=4'hF
- Sub-module `nubus_slot_decode`: combinational hit decode from AD[31:24], ID and `SUPER_EN`; output `hit`.

## Test plan
- ID=4'h9, START with AD=32'hF900_0010, TM1=1, `lcl_rdy` tied high, `WAIT_MIN`=0 -> `lcl_addr`=30'h3E40_0004; ACK asserted two cycles after START; status 11; `dataoe`=1 for one cycle.
- ID=4'h9, START with AD=32'hFA00_0000 (other slot) and with AD=32'h9000_0000 while `SUPER_EN`=0 -> `lcl_req` never asserted, `ackoe` stays 0.
- Hit with `WAIT_MIN`=3, `lcl_rdy` high from the start -> ACK four cycles after `lcl_req` rises. Repeat with `lcl_err`=1 -> status 01, `dataoe`=0. Repeat with `lcl_busy`=1 -> status 00.
- Hit with `lcl_rdy` held low, `TMO_CYCLES`=200 -> ACK with status 01 exactly 201 cycles after START; a START on the next cycle is accepted.
- Attention cycle START=1, ACK=1, {TM1,TM0}=01 -> `lcl_lock`=1 and no `lcl_req`; a later attention with 11 -> `lcl_lock`=0. A START+ACK carrying slot-hit address bits still produces no transaction.
- Drop `nub_resetn` mid-REQ -> all outputs 0 immediately, no ACK after release, and the next START is decoded normally.

Source files
------------

// File: rtl/nubus_pkg.sv
// -----------------------------------------------------------------------------
// nubus_pkg
// Shared types and constants for the NuBus slave responder: FSM state type,
// ACK-cycle status codes, attention-cycle codes, the slot-space nibble and a
// saturating counter helper.
// -----------------------------------------------------------------------------
package nubus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } nbs_state_t;

    // Status driven on {TM1,TM0} during the ACK cycle. 2'b10 is never used.
    localparam logic [1:0] ST_COMPLETE = 2'b11;
    localparam logic [1:0] ST_ERROR    = 2'b01;
    localparam logic [1:0] ST_RETRY    = 2'b00;

    // {TM1,TM0} codes carried by attention cycles (START and ACK together).
    localparam logic [1:0] ATTN_LOCK = 2'b01;
    localparam logic [1:0] ATTN_NULL = 2'b11;

    // Upper address nibble that selects standard slot space.
    localparam logic [3:0] SLOT_SPACE = 4'hF;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/nubus_slot_decode.sv
// -----------------------------------------------------------------------------
// nubus_slot_decode
// Combinational address decode for this card.
//   ad_hi  in  8  AD[31:24] of the current bus cycle
//   id     in  4  backplane slot ID
//   hit    out 1  address falls in this card's slot (or super-slot) space
// -----------------------------------------------------------------------------
module nubus_slot_decode #(
    parameter bit SUPER_EN = 1'b1
) (
    input  logic [7:0] ad_hi,
    input  logic [3:0] id,
    output logic       hit
);
    import nubus_pkg::*;

    logic slot_hit;
    logic super_hit;

    // Slot space: $Fs00_0000 - $FsFF_FFFF for slot s.
    assign slot_hit  = (ad_hi[7:4] == SLOT_SPACE) && (ad_hi[3:0] == id);
    // Super-slot space: $s000_0000 - $sFFF_FFFF. ID F would alias slot space
    // itself, so it never claims a super slot.
    assign super_hit = SUPER_EN && (ad_hi[7:4] == id) && (id != SLOT_SPACE);
    assign hit       = slot_hit || super_hit;

endmodule

// File: rtl/nubus_slave_resp.sv
// -----------------------------------------------------------------------------
// nubus_slave_resp
// NuBus target-side responder. Decodes address cycles aimed at this card,
// hands them to the local bus, and drives a one-cycle ACK with a status code.
// Also tracks lock/null attention cycles.
//   nub_clkn, nub_resetn         clock (rising edge) / async active-low reset
//   ID                           slot ID
//   START, ACK, TM1, TM0, AD     NuBus inputs (asserted = 1)
//   lcl_req, lcl_addr, lcl_mode  local request, latched AD[31:2], {TM,AD[1:0]}
//   lcl_rdy, lcl_err, lcl_busy   local completion and its qualifiers
//   lcl_lock                     lock-attention in effect
//   ack_out, tm1_out, tm0_out    ACK and status to drive on the bus
//   ackoe, dataoe                transceiver enables for ACK/TM and AD
// -----------------------------------------------------------------------------
module nubus_slave_resp #(
    parameter int WAIT_MIN   = 0,
    parameter int TMO_CYCLES = 200,
    parameter bit SUPER_EN   = 1'b1
) (
    input  logic        nub_clkn,
    input  logic        nub_resetn,
    input  logic [3:0]  ID,
    input  logic        START,
    input  logic        ACK,
    input  logic        TM1,
    input  logic        TM0,
    input  logic [31:0] AD,
    output logic        lcl_req,
    output logic [29:0] lcl_addr,
    output logic [3:0]  lcl_mode,
    input  logic        lcl_rdy,
    input  logic        lcl_err,
    input  logic        lcl_busy,
    output logic        lcl_lock,
    output logic        ack_out,
    output logic        tm1_out,
    output logic        tm0_out,
    output logic        ackoe,
    output logic        dataoe
);
    import nubus_pkg::*;

    // The ACK port shadows the imported state literal of the same name, so
    // the ACK state is always written with its package scope.

    localparam logic [7:0] WAIT_MIN_C = 8'(WAIT_MIN);
    localparam logic [7:0] TMO_LAST   = 8'(TMO_CYCLES - 1);

    nbs_state_t  state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic [3:0]  mode_q, mode_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic [1:0]  status_q, status_d;
    logic        lock_q, lock_d;

    logic hit;
    logic wait_ok;
    logic attn_cycle;
    logic addr_cycle;

    nubus_slot_decode #(.SUPER_EN(SUPER_EN)) u_slot_decode (
        .ad_hi (AD[31:24]),
        .id    (ID),
        .hit   (hit)
    );

    // With no minimum wait the comparison is dropped rather than left as an
    // always-true unsigned compare.
    generate
        if (WAIT_MIN == 0) begin : g_no_wait
            assign wait_ok = 1'b1;
        end else begin : g_wait
            assign wait_ok = (wait_cnt_q >= WAIT_MIN_C);
        end
    endgenerate

    assign attn_cycle = START && ACK;
    assign addr_cycle = START && !ACK;

    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned, which would infer a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        mode_d     = mode_q;
        wait_cnt_d = wait_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        status_d   = status_q;
        lock_d     = lock_q;

        // Attention cycles are observed regardless of transaction state.
        if (attn_cycle) begin
            if ({TM1, TM0} == ATTN_LOCK) begin
                lock_d = 1'b1;
            end else if ({TM1, TM0} == ATTN_NULL) begin
                lock_d = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                if (addr_cycle && hit) begin
                    state_d    = REQ;
                    addr_d     = AD[31:2];
                    mode_d     = {TM1, TM0, AD[1:0]};
                    wait_cnt_d = 8'd0;
                    tmo_cnt_d  = 8'd0;
                end
            end
            REQ: begin
                wait_cnt_d = sat_inc8(wait_cnt_q);
                tmo_cnt_d  = sat_inc8(tmo_cnt_q);
                // A qualifying ready in the last timeout cycle still wins.
                if (lcl_rdy && wait_ok) begin
                    state_d = nubus_pkg::ACK;
                    if (lcl_err) begin
                        status_d = ST_ERROR;
                    end else if (lcl_busy) begin
                        status_d = ST_RETRY;
                    end else begin
                        status_d = ST_COMPLETE;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d  = nubus_pkg::ACK;
                    status_d = ST_ERROR;
                end
            end
            nubus_pkg::ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            mode_q     <= '0;
            wait_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            status_q   <= '0;
            lock_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q    <= state_d;
            addr_q     <= addr_d;
            mode_q     <= mode_d;
            wait_cnt_q <= wait_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            status_q   <= status_d;
            lock_q     <= lock_d;
        end
    end

    // Bus-facing strobes decode the registered state only.
    assign lcl_req  = (state_q == REQ);
    assign ack_out  = (state_q == nubus_pkg::ACK);
    assign ackoe    = ack_out;
    assign tm1_out  = ack_out && status_q[1];
    assign tm0_out  = ack_out && status_q[0];
    // Read data goes out only with a successful read (lcl_mode[3] = TM1).
    assign dataoe   = ack_out && mode_q[3] && (status_q == ST_COMPLETE);
    assign lcl_addr = addr_q;
    assign lcl_mode = mode_q;
    assign lcl_lock = lock_q;

endmodule
